// File: rtl/rrat_commit_unit_if.sv
// rtl/rrat_commit_unit_if.sv - ROB commit/flush, free-list and restore stream bundle
interface rrat_commit_unit_if #(
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 6,
    parameter int LANES  = 4
);
    logic                    commit_valid;
    logic [ARCH_W-1:0]       commit_arch;
    logic [PHYS_W-1:0]       commit_phys;
    logic                    flush;
    logic                    free_valid;
    logic [PHYS_W-1:0]       free_reg;
    logic                    restore_valid;
    logic [ARCH_W-1:0]       restore_base;
    logic [LANES*PHYS_W-1:0] restore_phys;
    logic                    restore_busy;
    logic                    restore_done;

    modport master (
        output commit_valid, commit_arch, commit_phys, flush,
        input  free_valid, free_reg, restore_valid, restore_base, restore_phys,
               restore_busy, restore_done
    );

    modport slave (
        input  commit_valid, commit_arch, commit_phys, flush,
        output free_valid, free_reg, restore_valid, restore_base, restore_phys,
               restore_busy, restore_done
    );
endinterface

// File: rtl/rrat_commit_unit.sv
// rtl/rrat_commit_unit.sv - retirement RAT with free-list return and flush restore stream
module rrat_commit_unit #(
    parameter int NUM_ARCH = 32,
    parameter int PHYS_W   = 6,
    parameter int LANES    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    rrat_commit_unit_if.slave          bus,
    output logic [NUM_ARCH*PHYS_W-1:0] rrat_map,
    output logic                       protocol_err
);
    localparam int ARCH_W = $clog2(NUM_ARCH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RESTORE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [PHYS_W-1:0] map_q  [NUM_ARCH];
    logic [PHYS_W-1:0] map_d  [NUM_ARCH];
    logic [PHYS_W-1:0] snap_q [NUM_ARCH];
    logic [1:0]        state_q;
    logic [ARCH_W-1:0] base_q;
    logic              free_valid_q;
    logic [PHYS_W-1:0] free_reg_q;

    logic              commit_hit;
    logic [PHYS_W-1:0] old_phys;
    logic              same_phys;
    logic              do_write;

    // Arch 0 is hardwired, and re-committing the mapped phys would free a live register.
    assign commit_hit = bus.commit_valid && (bus.commit_arch != '0);
    assign old_phys   = map_q[bus.commit_arch];
    assign same_phys  = commit_hit && (bus.commit_phys == old_phys);
    assign do_write   = commit_hit && !same_phys;

    // Next map with this cycle's commit applied, so a same-cycle flush snapshots it.
    always_comb begin
        map_d = map_q;
        if (do_write) begin
            map_d[bus.commit_arch] = bus.commit_phys;
        end
    end

    // Committed map register; reset to the identity mapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= PHYS_W'(i);
            end
        end else begin
            map_q <= map_d;
        end
    end

    // Superseded phys goes back to the free list one cycle after the commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_valid_q <= 1'b0;
            free_reg_q   <= '0;
        end else begin
            free_valid_q <= do_write;
            free_reg_q   <= old_phys;
        end
    end

    // Sticky error: redundant commit, or any commit while the ROB should be empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if (same_phys || (bus.commit_valid && state_q == RESTORE)) begin
            protocol_err <= 1'b1;
        end
    end

    // Restore sequencer: snapshot on flush, walk the snapshot LANES entries per beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            for (int i = 0; i < NUM_ARCH; i++) begin
                snap_q[i] <= '0;
            end
        end else if (bus.flush) begin
            state_q <= RESTORE;
            base_q  <= '0;
            snap_q  <= map_d;
        end else begin
            case (state_q)
                RESTORE: begin
                    if (base_q == ARCH_W'(NUM_ARCH - LANES)) begin
                        state_q <= DONE;
                        base_q  <= '0;
                    end else begin
                        base_q <= base_q + ARCH_W'(LANES);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.free_valid    = free_valid_q;
    assign bus.free_reg      = free_reg_q;
    assign bus.restore_valid = (state_q == RESTORE);
    assign bus.restore_busy  = (state_q == RESTORE);
    assign bus.restore_done  = (state_q == DONE);
    assign bus.restore_base  = (state_q == RESTORE) ? base_q : '0;

    // Beat lanes read from the snapshot; zero outside RESTORE.
    always_comb begin
        bus.restore_phys = '0;
        if (state_q == RESTORE) begin
            for (int k = 0; k < LANES; k++) begin
                bus.restore_phys[k*PHYS_W +: PHYS_W] = snap_q[base_q + ARCH_W'(k)];
            end
        end
    end

    // Flattened live map for rename and debug.
    always_comb begin
        rrat_map = '0;
        for (int i = 0; i < NUM_ARCH; i++) begin
            rrat_map[i*PHYS_W +: PHYS_W] = map_q[i];
        end
    end
endmodule

// File: tb/tb_rrat_commit_unit.sv
// tb/tb_rrat_commit_unit.sv - scoreboard bench for rrat_commit_unit
module tb_rrat_commit_unit;
    logic         clk;
    logic         reset;
    logic [191:0] rrat_map;
    logic         protocol_err;

    rrat_commit_unit_if #(.ARCH_W(5), .PHYS_W(6), .LANES(4)) bus ();

    rrat_commit_unit #(.NUM_ARCH(32), .PHYS_W(6), .LANES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .rrat_map     (rrat_map),
        .protocol_err (protocol_err)
    );

    typedef struct {
        int          base;
        logic [23:0] phys;
    } beat_t;

    int          checks_total;
    int          checks_passed;
    int          done_cnt;
    int          model [32];
    int          free_q [$];
    beat_t       beat_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [5:0] map_at(input int i);
        logic [191:0] m;
        m = rrat_map;
        return m[i*6 +: 6];
    endfunction

    task automatic push_beats(input int first, input int last);
        beat_t b;
        for (int n = first; n <= last; n++) begin
            b.base = n * 4;
            b.phys = '0;
            for (int k = 0; k < 4; k++) b.phys[k*6 +: 6] = 6'(model[n*4 + k]);
            beat_q.push_back(b);
        end
    endtask

    task automatic cyc(input logic cv, input logic [4:0] ca, input logic [5:0] cp, input logic fl);
        bus.commit_valid = cv;
        bus.commit_arch  = ca;
        bus.commit_phys  = cp;
        bus.flush        = fl;
        @(posedge clk);
        #1;
        bus.commit_valid = 1'b0;
        bus.commit_arch  = '0;
        bus.commit_phys  = '0;
        bus.flush        = 1'b0;
    endtask

    // Monitor: pops expected free/beat responses whenever the DUT presents one.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (bus.free_valid) begin
                if (free_q.size() == 0) chk("free_unexpected", 32'd1, 32'd0);
                else chk("free_reg", 32'(bus.free_reg), 32'(free_q.pop_front()));
            end
            if (bus.restore_valid) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
                else begin
                    e = beat_q.pop_front();
                    chk("restore_base", 32'(bus.restore_base), 32'(e.base));
                    chk("restore_phys", 32'(bus.restore_phys), 32'(e.phys));
                end
            end
            if (bus.restore_done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks_total = 0;
        checks_passed = 0;
        done_cnt = 0;
        for (int i = 0; i < 32; i++) model[i] = i;
        bus.commit_valid = 1'b0;
        bus.commit_arch  = '0;
        bus.commit_phys  = '0;
        bus.flush        = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        for (int i = 0; i < 32; i++) chk("reset_map", 32'(map_at(i)), 32'(i));
        chk("reset_free_valid", 32'(bus.free_valid), 32'd0);
        chk("reset_restore_valid", 32'(bus.restore_valid), 32'd0);
        chk("reset_busy", 32'(bus.restore_busy), 32'd0);
        chk("reset_done", 32'(bus.restore_done), 32'd0);
        chk("reset_err", 32'(protocol_err), 32'd0);
        chk("reset_base", 32'(bus.restore_base), 32'd0);
        chk("reset_phys", 32'(bus.restore_phys), 32'd0);

        // Back-to-back commits to arch 5: frees 5, then 40.
        free_q.push_back(5);
        cyc(1'b1, 5'd5, 6'd40, 1'b0);
        chk("map5_after_40", 32'(map_at(5)), 32'd40);
        free_q.push_back(40);
        cyc(1'b1, 5'd5, 6'd41, 1'b0);
        chk("map5_after_41", 32'(map_at(5)), 32'd41);
        model[5] = 41;

        // Arch 0 commit is ignored.
        cyc(1'b1, 5'd0, 6'd33, 1'b0);
        chk("map0_unchanged", 32'(map_at(0)), 32'd0);
        @(negedge clk);
        chk("arch0_no_free", 32'(bus.free_valid), 32'd0);
        chk("arch0_no_err", 32'(protocol_err), 32'd0);

        // Commit (3,50) together with flush.
        model[3] = 50;
        free_q.push_back(3);
        push_beats(0, 7);
        cyc(1'b1, 5'd3, 6'd50, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("busy_window", 32'(bus.restore_busy), (c <= 8) ? 32'd1 : 32'd0);
            chk("done_pulse", 32'(bus.restore_done), (c == 9) ? 32'd1 : 32'd0);
            if (c == 1) chk("beat0_lane3", 32'(bus.restore_phys[23:18]), 32'd50);
            @(posedge clk);
            #1;
        end
        chk("err_after_flush", 32'(protocol_err), 32'd0);
        cyc(1'b0, 5'd0, 6'd0, 1'b0);

        // Flush, then re-flush while beat 5 is on the bus.
        push_beats(0, 5);
        cyc(1'b0, 5'd0, 6'd0, 1'b1);
        repeat (5) cyc(1'b0, 5'd0, 6'd0, 1'b0);
        push_beats(0, 7);
        cyc(1'b0, 5'd0, 6'd0, 1'b1);
        // Commit mid-restore: live map moves, beats keep the snapshot.
        cyc(1'b0, 5'd0, 6'd0, 1'b0);
        free_q.push_back(7);
        cyc(1'b1, 5'd7, 6'd60, 1'b0);
        model[7] = 60;
        chk("map7_live", 32'(map_at(7)), 32'd60);
        chk("err_commit_in_restore", 32'(protocol_err), 32'd1);
        repeat (10) cyc(1'b0, 5'd0, 6'd0, 1'b0);
        chk("done_count", 32'(done_cnt), 32'd2);

        // Reset in the middle of a restore.
        push_beats(0, 1);
        cyc(1'b0, 5'd0, 6'd0, 1'b1);
        cyc(1'b0, 5'd0, 6'd0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 5'd0, 6'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = i;
        @(negedge clk);
        chk("midreset_busy", 32'(bus.restore_busy), 32'd0);
        chk("midreset_valid", 32'(bus.restore_valid), 32'd0);
        chk("midreset_err", 32'(protocol_err), 32'd0);
        chk("midreset_map3", 32'(map_at(3)), 32'd3);
        chk("midreset_map5", 32'(map_at(5)), 32'd5);
        chk("midreset_map7", 32'(map_at(7)), 32'd7);

        // Redundant commit: no free, error set.
        cyc(1'b1, 5'd9, 6'd9, 1'b0);
        @(negedge clk);
        chk("same_phys_no_free", 32'(bus.free_valid), 32'd0);
        chk("same_phys_err", 32'(protocol_err), 32'd1);
        chk("same_phys_map9", 32'(map_at(9)), 32'd9);
        repeat (3) cyc(1'b0, 5'd0, 6'd0, 1'b0);

        chk("free_q_drained", 32'(free_q.size()), 32'd0);
        chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
        chk("done_count_final", 32'(done_cnt), 32'd2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
